max7219_if_arbiter: RTL

- Shares one max7219_if serial engine between G_NB_REQ requesters, e.g. max7219_cmd_decod (static display) and a scroller or init sequencer.
- Grants are frame-atomic: a granted requester keeps the engine across several 16-bit words until it sends the word with en_load set (the word that latches the matrix chain) or drops its request.
- Arbitration is round-robin, with a watchdog that reclaims a stalled grant.
- Sits between the requesters' o_max7219_if_* outputs and the i_start / i_en_load / i_data inputs of max7219_if.

---
 rtl/max7219_if_arbiter_if.sv | 31 +++
 rtl/max7219_if_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/max7219_if_arbiter_if.sv
// Bundle of requester-side and engine-side signals around the max7219_if arbiter.
// slave = arbiter view, master = the requesters/engine driving it.
interface max7219_if_arbiter_if #(
    parameter int G_NB_REQ     = 2,
    parameter int G_DATA_WIDTH = 16
);
    logic [G_NB_REQ-1:0]              i_req;
    logic [G_NB_REQ-1:0]              i_start;
    logic [G_NB_REQ-1:0]              i_en_load;
    logic [G_NB_REQ*G_DATA_WIDTH-1:0] i_data;
    logic [G_NB_REQ-1:0]              o_grant;
    logic [G_NB_REQ-1:0]              o_done;
    logic                             o_max7219_if_start;
    logic                             o_max7219_if_en_load;
    logic [G_DATA_WIDTH-1:0]          o_max7219_if_data;
    logic                             i_max7219_if_done;
    logic                             o_collision;
    logic                             o_timeout;

    modport slave (
        input  i_req, i_start, i_en_load, i_data, i_max7219_if_done,
        output o_grant, o_done, o_max7219_if_start, o_max7219_if_en_load,
               o_max7219_if_data, o_collision, o_timeout
    );

    modport master (
        output i_req, i_start, i_en_load, i_data, i_max7219_if_done,
        input  o_grant, o_done, o_max7219_if_start, o_max7219_if_en_load,
               o_max7219_if_data, o_collision, o_timeout
    );
endinterface

// File: rtl/max7219_if_arbiter.sv
// Frame-atomic round-robin arbiter sharing one max7219_if serial engine
// between several requesters, with a watchdog on idle grants.
module max7219_if_arbiter #(
    parameter int G_NB_REQ     = 2,
    parameter int G_DATA_WIDTH = 16,
    parameter int G_TIMEOUT    = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    max7219_if_arbiter_if.slave  bus
);
    localparam int PTR_W = (G_NB_REQ > 1) ? $clog2(G_NB_REQ) : 1;
    localparam int WD_W  = $clog2(G_TIMEOUT);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(G_NB_REQ - 1);
    localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(G_TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_BUSY} state_t;

    state_t                  state_q;
    logic [G_NB_REQ-1:0]     grant_q;
    logic [PTR_W-1:0]        gidx_q;
    logic [PTR_W-1:0]        rr_q;
    logic [WD_W-1:0]         wdog_q;
    logic                    last_word_q;
    logic [G_NB_REQ-1:0]     done_q;
    logic                    start_q;
    logic                    en_load_q;
    logic [G_DATA_WIDTH-1:0] data_q;
    logic                    coll_q;
    logic                    tout_q;

    logic                    pick_vld_d;
    logic [PTR_W-1:0]        pick_idx_d;
    logic [G_NB_REQ-1:0]     pick_oh_d;
    logic [PTR_W-1:0]        rr_nxt_d;
    logic                    coll_d;
    logic [G_DATA_WIDTH-1:0] word_d [G_NB_REQ];

    always_comb begin
        for (int i = 0; i < G_NB_REQ; i++) begin
            word_d[i] = bus.i_data[i*G_DATA_WIDTH +: G_DATA_WIDTH];
        end
    end

    // Descending scan so the candidate closest to rr_q (lowest offset) wins.
    always_comb begin
        logic [PTR_W-1:0] cand;
        int               pos;
        pick_vld_d = 1'b0;
        pick_idx_d = '0;
        pick_oh_d  = '0;
        cand       = '0;
        for (int i = G_NB_REQ - 1; i >= 0; i--) begin
            pos = int'(rr_q) + i;
            if (pos >= G_NB_REQ) begin
                pos = pos - G_NB_REQ;
            end
            cand = PTR_W'(pos);
            if (bus.i_req[cand]) begin
                pick_vld_d = 1'b1;
                pick_idx_d = cand;
            end
        end
        pick_oh_d[pick_idx_d] = pick_vld_d;
    end

    always_comb begin
        rr_nxt_d = (gidx_q == LAST_IDX) ? '0 : gidx_q + PTR_W'(1);
        coll_d   = (|(bus.i_start & ~grant_q)) ||
                   ((state_q == S_BUSY) && (|(bus.i_start & grant_q)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            gidx_q      <= '0;
            rr_q        <= '0;
            wdog_q      <= '0;
            last_word_q <= 1'b0;
            done_q      <= '0;
            start_q     <= 1'b0;
            en_load_q   <= 1'b0;
            data_q      <= '0;
            coll_q      <= 1'b0;
            tout_q      <= 1'b0;
        end else begin
            done_q  <= '0;
            start_q <= 1'b0;
            tout_q  <= 1'b0;
            coll_q  <= coll_d;
            case (state_q)
                S_IDLE: begin
                    if (pick_vld_d) begin
                        grant_q <= pick_oh_d;
                        gidx_q  <= pick_idx_d;
                        wdog_q  <= '0;
                        state_q <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (bus.i_start[gidx_q]) begin
                        start_q     <= 1'b1;
                        data_q      <= word_d[gidx_q];
                        en_load_q   <= bus.i_en_load[gidx_q];
                        last_word_q <= bus.i_en_load[gidx_q];
                        state_q     <= S_BUSY;
                    end else if (!bus.i_req[gidx_q] || (wdog_q == WD_MAX)) begin
                        // A timeout is only flagged when the requester still wants the engine.
                        tout_q  <= bus.i_req[gidx_q];
                        grant_q <= '0;
                        rr_q    <= rr_nxt_d;
                        state_q <= S_IDLE;
                    end else begin
                        wdog_q <= wdog_q + WD_W'(1);
                    end
                end
                S_BUSY: begin
                    if (bus.i_max7219_if_done) begin
                        done_q <= grant_q;
                        if (last_word_q || !bus.i_req[gidx_q]) begin
                            grant_q <= '0;
                            rr_q    <= rr_nxt_d;
                            state_q <= S_IDLE;
                        end else begin
                            wdog_q  <= '0;
                            state_q <= S_GRANT;
                        end
                    end
                end
                default: begin
                    grant_q <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_grant              = grant_q;
    assign bus.o_done               = done_q;
    assign bus.o_max7219_if_start   = start_q;
    assign bus.o_max7219_if_en_load = en_load_q;
    assign bus.o_max7219_if_data    = data_q;
    assign bus.o_collision          = coll_q;
    assign bus.o_timeout            = tout_q;
endmodule
